// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared state/grant encodings for the unified memory port arbiter
package riscv_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} arb_gnt_t;
  localparam int MAX_RD_LAT = 8;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: data-first winner select with a streak counter that bounds fetch starvation
module arb_pick
  import riscv_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     Rst,
  input  logic     i_req,
  input  logic     d_req,
  input  logic     grant_strobe,
  output arb_gnt_t winner
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak;
  always_comb
    winner = (d_req && !(i_req && streak == SW'(STARVE_MAX))) ? GNT_D : i_req ? GNT_I : GNT_NONE;
  // a data win with fetch waiting implies streak < STARVE_MAX, so the increment saturates naturally
  always_ff @(posedge clk)
    if (!Rst) streak <= '0;
    else if (grant_strobe) streak <= (winner == GNT_D && i_req) ? streak + 1'b1 : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data access,
// stalling the pipeline via mem_hold while an access is outstanding.
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_hold,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  localparam int CW = $clog2(RD_LAT + 1);
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("mem_port_arbiter: RD_LAT must be 1..%0d", MAX_RD_LAT);
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be 1..15");
  end
  arb_state_t        state, nxt;
  arb_gnt_t          grant, winner;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [3:0]        a_be;
  logic [DATA_W-1:0] a_wdata;
  logic              grant_strobe, issue, last;
  arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk(clk), .Rst(Rst), .i_req(i_req), .d_req(d_req),
    .grant_strobe(grant_strobe), .winner(winner)
  );
  always_comb begin
    issue        = state == ARB_ISSUE;
    last         = state == ARB_WAIT && cnt == CW'(1);
    grant_strobe = Rst && state == ARB_IDLE && (i_req || d_req);
    nxt = state == ARB_IDLE  ? ((i_req || d_req) ? ARB_ISSUE : ARB_IDLE) :
          state == ARB_ISSUE ? (a_we ? ARB_RESP : ARB_WAIT) :
          state == ARB_WAIT  ? (last ? ARB_RESP : ARB_WAIT) : ARB_IDLE;
    // an all-zero byte-enable write never touches the macro but still completes
    m_en     = issue && !(a_we && a_be == 4'b0);
    m_we     = (issue && a_we) ? a_be : 4'b0;
    m_addr   = issue ? a_addr : '0;
    m_wdata  = issue ? a_wdata : '0;
    i_valid  = state == ARB_RESP && grant == GNT_I;
    d_valid  = state == ARB_RESP && grant == GNT_D;
    mem_hold = Rst && (state == ARB_IDLE ? (i_req || d_req) :
                       state == ARB_RESP ? (grant == GNT_I ? d_req : i_req) : 1'b1);
  end
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state   <= ARB_IDLE;
      grant   <= GNT_NONE;
      cnt     <= '0;
      a_addr  <= '0;
      a_we    <= 1'b0;
      a_be    <= 4'b0;
      a_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= nxt;
      if (grant_strobe) begin
        grant   <= winner;
        a_addr  <= winner == GNT_D ? d_addr : i_addr;
        a_we    <= winner == GNT_D && d_we;
        a_be    <= d_be;
        a_wdata <= d_wdata;
      end
      if (issue) cnt <= CW'(RD_LAT);
      else if (state == ARB_WAIT) cnt <= cnt - 1'b1;
      if (last && grant == GNT_I) i_rdata <= m_rdata;
      if (last && grant == GNT_D) d_rdata <= m_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation bound and reset
module tb_mem_port_arbiter;
  logic        clk, Rst, i_req, d_req, d_we;
  logic [3:0]  d_be, m_we;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_valid, d_valid, mem_hold, m_en;
  logic [31:0] p0, p1;
  int n_chk = 0, n_pass = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .Rst(Rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .mem_hold(mem_hold), .m_en(m_en), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] rd(input logic [31:0] a);
    return a == 32'h100 ? 32'h00500093 : a ^ 32'hA5A50000;
  endfunction
  // two-cycle read pipeline; junk appears whenever no read was issued
  always @(posedge clk) begin
    p0 <= (m_en && m_we == 4'b0) ? rd(m_addr) : 32'hBAD0BAD0;
    p1 <= p0;
  end
  assign m_rdata = p1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int d_before, d_after, fetches, pulses;
    Rst = 0; i_req = 1; d_req = 1; d_we = 0; d_be = 4'h0;
    i_addr = 32'h0; d_addr = 32'h3000; d_wdata = 32'h0;
    repeat (3) tick;
    check("rst_m_en", m_en, 0);
    check("rst_hold", mem_hold, 0);
    check("rst_valid", {i_valid, d_valid}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    Rst = 1; #1;
    check("rel_hold", mem_hold, 1);
    tick;
    check("rel_issue_en", m_en, 1);
    check("rel_issue_addr", m_addr, 32'h3000);
    i_req = 0; d_req = 0;
    repeat (3) tick;
    check("rel_d_valid", d_valid, 1);
    check("rel_d_rdata", d_rdata, 32'hA5A53000);
    tick;
    check("rel_d_valid_off", d_valid, 0);
    // single fetch; deasserting the request after grant must not cancel it
    i_req = 1; i_addr = 32'h100; #1;
    check("f_hold_c0", mem_hold, 1);
    tick;
    check("f_m_en_c1", m_en, 1);
    check("f_m_addr_c1", m_addr, 32'h100);
    i_req = 0; i_addr = 32'hFFFF; #1;
    check("f_hold_c1", mem_hold, 1);
    tick;
    check("f_hold_c2", mem_hold, 1);
    check("f_m_en_c2", m_en, 0);
    tick;
    check("f_valid_c3", i_valid, 0);
    tick;
    check("f_valid_c4", i_valid, 1);
    check("f_rdata_c4", i_rdata, 32'h00500093);
    check("f_hold_c4", mem_hold, 0);
    tick;
    check("f_valid_c5", i_valid, 0);
    // data write
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    tick;
    check("w_m_we", m_we, 4'b0011);
    check("w_m_addr", m_addr, 32'h2004);
    check("w_m_wdata", m_wdata, 32'hDEADBEEF);
    check("w_m_en", m_en, 1);
    d_req = 0; d_we = 0; d_wdata = 0;
    tick;
    check("w_d_valid", d_valid, 1);
    check("w_i_valid", i_valid, 0);
    check("w_hold", mem_hold, 0);
    tick;
    // zero byte-enable write: no memory enable, still completes
    d_req = 1; d_we = 1; d_be = 4'b0000; d_addr = 32'h2008;
    tick;
    check("w0_m_en", m_en, 0);
    check("w0_m_we", m_we, 0);
    d_req = 0; d_we = 0;
    tick;
    check("w0_d_valid", d_valid, 1);
    tick;
    // simultaneous requests: data first
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h40; i_addr = 32'h200;
    tick;
    check("s_d_first", m_addr, 32'h40);
    d_req = 0;
    repeat (3) tick;
    check("s_d_valid", d_valid, 1);
    check("s_d_rdata", d_rdata, 32'hA5A50040);
    check("s_hold_resp", mem_hold, 1);
    tick;
    check("s_hold_idle", mem_hold, 1);
    check("s_idle_en", m_en, 0);
    tick;
    check("s_i_issue", m_addr, 32'h200);
    i_req = 0;
    repeat (3) tick;
    check("s_i_valid", i_valid, 1);
    check("s_i_rdata", i_rdata, 32'hA5A50200);
    check("s_d_hold_val", d_rdata, 32'hA5A50040);
    tick;
    // starvation bound: 4 data grants, then a fetch, then 4 more data grants
    i_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; i_addr = 32'h300; d_addr = 32'h500;
    d_before = 0; d_after = 0; fetches = 0;
    for (int k = 0; k < 100 && fetches < 2; k++) begin
      tick;
      if (m_en && m_we != 4'b0) begin
        if (fetches == 0) d_before++;
        else d_after++;
      end else if (m_en) fetches++;
    end
    check("st_fetches", fetches, 2);
    check("st_d_before", d_before, 4);
    check("st_d_after", d_after, 4);
    i_req = 0; d_req = 0; d_we = 0;
    repeat (5) tick;
    check("st_idle_hold", mem_hold, 0);
    // reset during the second wait cycle of a read
    d_req = 1; d_addr = 32'h80;
    tick;
    d_req = 0;
    tick;
    tick;
    Rst = 0; #1;
    check("rw_hold_in_rst", mem_hold, 0);
    tick;
    check("rw_d_valid", d_valid, 0);
    check("rw_d_rdata", d_rdata, 0);
    check("rw_i_rdata", i_rdata, 0);
    Rst = 1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (i_valid || d_valid || m_en) pulses++;
    end
    check("rw_no_pulse", pulses, 0);
    check("rw_hold_after", mem_hold, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
